// File: rtl/key_number_counter_if.sv
// -----------------------------------------------------------------------------
// key_number_counter_if
// Purpose : groups the button inputs and the count outputs of
//           key_number_counter into one bundle.
// Signals :
//   key_inc_n   - raw increment button, asynchronous, 0 = pressed
//   key_dec_n   - raw decrement button, asynchronous, 0 = pressed
//   number_data - current count 0..MAX_VALUE, feeds the display stage
//   step_pulse  - one-cycle high whenever number_data changes
// Modports:
//   master - drives the buttons, observes the count (button board / bench)
//   slave  - the counter itself
// -----------------------------------------------------------------------------
interface key_number_counter_if;
    logic       key_inc_n;
    logic       key_dec_n;
    logic [7:0] number_data;
    logic       step_pulse;

    modport master (
        output key_inc_n,
        output key_dec_n,
        input  number_data,
        input  step_pulse
    );

    modport slave (
        input  key_inc_n,
        input  key_dec_n,
        output number_data,
        output step_pulse
    );
endinterface

// File: rtl/key_number_counter.sv
// -----------------------------------------------------------------------------
// key_number_counter
// Purpose : turns two raw active-low push buttons into a wrap-around up/down
//           count 0..MAX_VALUE with debounce and hold-to-auto-repeat.
// Ports   :
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - key_number_counter_if.slave (key_inc_n, key_dec_n in;
//           number_data, step_pulse out)
// Pipeline: 2-flop sync -> debounce -> registered press event -> FSM decides
//           a step -> count register. A clean press shows up on number_data
//           2 + DEBOUNCE_CYCLES + 2 edges after the pin falls.
// -----------------------------------------------------------------------------
module key_number_counter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000,
    parameter int MAX_VALUE       = 99
) (
    input  logic                  clk,
    input  logic                  rst_n,
    key_number_counter_if.slave   bus
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [7:0]       MAX_V      = 8'(MAX_VALUE);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LAST   = TMR_W'(REPEAT_PERIOD - 1);

    // Key index 0 = increment, 1 = decrement.
    logic [1:0] w_key_raw;
    logic [1:0] w_deb;      // debounced level, 1 = released
    logic [1:0] w_press;    // one-cycle press event

    assign w_key_raw = {bus.key_dec_n, bus.key_inc_n};

    // -------------------------------------------------------------------------
    // Per-key synchroniser, debouncer and press-edge detector
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic             r_meta;
            logic             r_sync;
            logic             r_deb;
            logic             r_deb_d;
            logic             r_press;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_meta  <= 1'b1;
                    r_sync  <= 1'b1;
                    r_deb   <= 1'b1;
                    r_deb_d <= 1'b1;
                    r_press <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_meta  <= w_key_raw[gi];
                    r_sync  <= r_meta;
                    r_deb_d <= r_deb;
                    // Registered so the FSM acts one stage after the debounced
                    // level falls; only the 1->0 edge is an event.
                    r_press <= r_deb_d & ~r_deb;
                    if (r_sync != r_deb) begin
                        if (r_cnt == DEB_LAST) begin
                            r_deb <= r_sync;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_deb[gi]   = r_deb;
            assign w_press[gi] = r_press;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control FSM: one active key at a time
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic             r_active, w_active_next;   // 0 = inc key, 1 = dec key
    logic [TMR_W-1:0] r_timer, w_timer_next;
    logic             w_step;
    logic             w_step_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_active <= w_active_next;
            r_timer  <= w_timer_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_active_next = r_active;
        w_timer_next  = r_timer;
        w_step        = 1'b0;
        w_step_up     = ~r_active;
        case (r_state)
            S_IDLE: begin
                // Both keys pressed in the same cycle is ambiguous: ignore.
                if (w_press[0] ^ w_press[1]) begin
                    w_step        = 1'b1;
                    w_step_up     = w_press[0];
                    w_active_next = w_press[1];
                    w_timer_next  = '0;
                    w_state_next  = S_DELAY;
                end
            end
            S_DELAY: begin
                // Release wins over a step falling in the same cycle.
                if (w_deb[r_active]) begin
                    w_timer_next = '0;
                    w_state_next = S_IDLE;
                end else if (r_timer == DELAY_LAST) begin
                    w_step       = 1'b1;
                    w_timer_next = '0;
                    w_state_next = S_REPEAT;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_REPEAT: begin
                if (w_deb[r_active]) begin
                    w_timer_next = '0;
                    w_state_next = S_IDLE;
                end else if (r_timer == PER_LAST) begin
                    w_step       = 1'b1;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: begin
                w_timer_next = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Wrap-around counter
    // -------------------------------------------------------------------------
    logic [7:0] r_number;
    logic       r_step_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_number     <= 8'd0;
            r_step_pulse <= 1'b0;
        end else begin
            r_step_pulse <= w_step;
            if (w_step) begin
                if (w_step_up) begin
                    r_number <= (r_number >= MAX_V) ? 8'd0 : r_number + 8'd1;
                end else begin
                    r_number <= (r_number == 8'd0) ? MAX_V : r_number - 8'd1;
                end
            end
        end
    end

    assign bus.number_data = r_number;
    assign bus.step_pulse  = r_step_pulse;

endmodule

// File: tb/tb_key_number_counter.sv
// -----------------------------------------------------------------------------
// tb_key_number_counter
// Purpose : self-checking bench for key_number_counter with small timing
//           parameters (DEBOUNCE 4, REPEAT_DELAY 20, REPEAT_PERIOD 5, MAX 99).
//           Inputs change 1 time unit after a rising edge; outputs are read
//           there too, or on the falling edge by the monitor.
// -----------------------------------------------------------------------------
module tb_key_number_counter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    key_number_counter_if bus();

    key_number_counter #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5),
        .MAX_VALUE       (99)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         pulse_cnt = 0;
    logic [7:0] prev_num  = 8'd0;
    bit         mon_en    = 1'b0;

    // step_pulse must be high exactly on the cycles where number_data changed,
    // and the count must never leave 0..99.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            n_checks++;
            if ((bus.number_data != prev_num) != bus.step_pulse) begin
                n_fail++;
                $display("FAIL pulse_vs_change: number %0d (was %0d) step_pulse=%0b, required pulse=%0b",
                         bus.number_data, prev_num, bus.step_pulse, bus.number_data != prev_num);
            end
            n_checks++;
            if (bus.number_data > 8'd99) begin
                n_fail++;
                $display("FAIL range: number_data=%0d, required <= 99", bus.number_data);
            end
            if (bus.step_pulse) pulse_cnt++;
        end
        prev_num = bus.number_data;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input bit inc, input bit dec, input int low, input int gap);
        bus.key_inc_n = ~inc;
        bus.key_dec_n = ~dec;
        run(low);
        bus.key_inc_n = 1'b1;
        bus.key_dec_n = 1'b1;
        run(gap);
    endtask

    typedef struct {
        bit inc;
        bit dec;
        int low;
        int exp_num;
        int exp_pulses;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int p0;
        int steps[$];
        int exp_steps[7];

        // Starting from count 1 after the single-press and glitch sequences.
        vecs[0] = '{inc: 1'b0, dec: 1'b1, low: 10, exp_num: 0,  exp_pulses: 1}; // 1 -> 0
        vecs[1] = '{inc: 1'b0, dec: 1'b1, low: 10, exp_num: 99, exp_pulses: 1}; // wrap down
        vecs[2] = '{inc: 1'b1, dec: 1'b0, low: 10, exp_num: 0,  exp_pulses: 1}; // wrap up
        vecs[3] = '{inc: 1'b1, dec: 1'b0, low: 3,  exp_num: 0,  exp_pulses: 0}; // too short
        vecs[4] = '{inc: 1'b1, dec: 1'b0, low: 4,  exp_num: 1,  exp_pulses: 1}; // just long enough
        vecs[5] = '{inc: 1'b1, dec: 1'b1, low: 10, exp_num: 1,  exp_pulses: 0}; // both at once
        vecs[6] = '{inc: 1'b0, dec: 1'b1, low: 4,  exp_num: 0,  exp_pulses: 1};
        vecs[7] = '{inc: 1'b0, dec: 1'b1, low: 3,  exp_num: 0,  exp_pulses: 0};

        exp_steps = '{8, 28, 33, 38, 43, 48, 53};

        // ---------------- reset ----------------
        bus.key_inc_n = 1'b1;
        bus.key_dec_n = 1'b1;
        rst_n = 1'b0;
        #1;
        check("reset_number", bus.number_data, 0);
        check("reset_pulse", bus.step_pulse, 0);
        run(3);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        run(50);
        check("idle_number", bus.number_data, 0);
        check("idle_pulses", pulse_cnt, 0);
        $display("reset/idle: number=%0d pulses=%0d", bus.number_data, pulse_cnt);

        // ---------------- single press, exact latency ----------------
        p0 = pulse_cnt;
        bus.key_inc_n = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("latency_hold_%0d", i), bus.number_data, 0);
        end
        tick();
        check("latency_edge8_number", bus.number_data, 1);
        check("latency_edge8_pulse", bus.step_pulse, 1);
        run(2);
        bus.key_inc_n = 1'b1;
        run(30);
        check("single_press_pulses", pulse_cnt - p0, 1);
        check("single_press_number", bus.number_data, 1);
        $display("single press: number=%0d pulses=%0d", bus.number_data, pulse_cnt - p0);

        // ---------------- glitch rejection ----------------
        p0 = pulse_cnt;
        repeat (5) press(1'b0, 1'b1, 3, 3);
        run(20);
        check("glitch_number", bus.number_data, 1);
        check("glitch_pulses", pulse_cnt - p0, 0);
        $display("glitch train: number=%0d pulses=%0d", bus.number_data, pulse_cnt - p0);

        // ---------------- table-driven presses ----------------
        for (int v = 0; v < 8; v++) begin
            p0 = pulse_cnt;
            press(vecs[v].inc, vecs[v].dec, vecs[v].low, 30);
            check($sformatf("vec%0d_number", v), bus.number_data, vecs[v].exp_num);
            check($sformatf("vec%0d_pulses", v), pulse_cnt - p0, vecs[v].exp_pulses);
            $display("vec %0d: inc=%0b dec=%0b low=%0d -> number=%0d pulses=%0d",
                     v, vecs[v].inc, vecs[v].dec, vecs[v].low, bus.number_data, pulse_cnt - p0);
        end

        // ---------------- bring count to 5 ----------------
        repeat (5) press(1'b1, 1'b0, 6, 20);
        check("preset_5", bus.number_data, 5);

        // ---------------- auto-repeat ----------------
        // Pin low at edge 0, released after edge 50 (debounced release at 56).
        bus.key_inc_n = 1'b0;
        for (int t = 1; t <= 80; t++) begin
            tick();
            if (bus.step_pulse) steps.push_back(t);
            if (t == 50) bus.key_inc_n = 1'b1;
        end
        check("repeat_step_count", steps.size(), 7);
        for (int k = 0; k < 7; k++) begin
            if (k < steps.size()) check($sformatf("repeat_step%0d_edge", k), steps[k], exp_steps[k]);
            else                  check($sformatf("repeat_step%0d_edge", k), -1, exp_steps[k]);
        end
        check("repeat_final", bus.number_data, 12);
        $display("auto-repeat: %0d steps, number=%0d", steps.size(), bus.number_data);

        // ---------------- contention ----------------
        // Inc held from edge 0, dec added at 35, inc released at 55 -> inc steps
        // at 8,28,33,...,58 (8 steps); dec never acts.
        p0 = pulse_cnt;
        bus.key_inc_n = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (t == 35) bus.key_dec_n = 1'b0;
            if (t == 55) bus.key_inc_n = 1'b1;
            if (t == 62) check("contention_after_inc_release", bus.number_data, 20);
        end
        check("contention_dec_held_number", bus.number_data, 20);
        bus.key_dec_n = 1'b1;
        run(20);
        check("contention_number", bus.number_data, 20);
        check("contention_pulses", pulse_cnt - p0, 8);
        $display("contention: number=%0d pulses=%0d", bus.number_data, pulse_cnt - p0);

        // ---------------- reset mid-REPEAT ----------------
        bus.key_inc_n = 1'b0;
        run(40);
        check("pre_reset_number", bus.number_data, 24);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_number", bus.number_data, 0);
        check("async_reset_pulse", bus.step_pulse, 0);
        run(2);
        rst_n = 1'b1;
        // Key still held: a fresh debounce from released state, step at edge 8.
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 7) check("post_reset_edge7", bus.number_data, 0);
            if (t == 8) check("post_reset_edge8", bus.number_data, 1);
        end
        bus.key_inc_n = 1'b1;
        run(30);
        check("post_reset_final", bus.number_data, 1);
        $display("reset mid-repeat: number=%0d", bus.number_data);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
